wc_stream_adapter: RTL and testbench

- Streaming front/back end for the wc Winograd core.
- Accepts a serial stream of W-bit signed samples on a valid/ready interface.
- Builds overlapping TILE-sample tiles with stride M and drives them, packed, onto wc's D input.
- After the core's fixed latency, captures wc's packed Z result and emits its M outputs serially on a valid/ready interface.
- This is the producer for D and the consumer for Z.

---
 rtl/wc_stream_adapter.sv | 122 ++++++++++++
 tb/tb_wc_stream_adapter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wc_stream_adapter.sv
// wc_stream_adapter
//   Streaming front/back end for the wc Winograd core. Collects a serial
//   stream of signed samples into overlapping TILE-sample tiles (stride M),
//   presents each tile on D, waits the core's fixed latency, captures the
//   packed result Z and replays its M elements serially downstream.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous reset, active-low
//   s_data   in   W-bit signed input sample
//   s_valid  in   s_data valid
//   s_ready  out  sample accepted this cycle (decoded from state and rst)
//   D        out  W*TILE packed tile to wc, element 0 in the MSBs
//   Z        in   W*M packed result from wc, element 0 in the MSBs
//   m_data   out  W-bit signed result element
//   m_valid  out  m_data valid
//   m_ready  in   downstream accepts m_data
module wc_stream_adapter #(
    parameter int W    = 10,
    parameter int TILE = 6,
    parameter int M    = 2,
    parameter int LAT  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic signed [W-1:0]   s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [W*TILE-1:0]     D,
    input  logic [W*M-1:0]        Z,
    output logic signed [W-1:0]   m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    localparam int NW = $clog2(TILE + 1);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int IW = (M > 1) ? $clog2(M) : 1;

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]           state;
    logic [NW-1:0]        need;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [IW-1:0]        idx_inc;
    logic [W*TILE-1:0]    win;
    logic [W*TILE-1:0]    win_nxt;
    logic [W*M-1:0]       res;
    logic signed [W-1:0]  res_e [M];

    // Window shifts toward element 0 (MSBs); the new sample lands in element TILE-1.
    assign win_nxt = {win[W*(TILE-1)-1:0], s_data};
    assign idx_inc = idx + 1'b1;

    assign s_ready = rst && (state == ST_FILL);

    always_comb begin
        for (int i = 0; i < M; i++) begin
            res_e[i] = res[W*(M-i)-1 -: W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_FILL;
            need    <= NW'(TILE);
            cnt     <= '0;
            idx     <= '0;
            win     <= '0;
            D       <= '0;
            res     <= '0;
            m_data  <= '0;
            m_valid <= 1'b0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (s_valid) begin
                        win  <= win_nxt;
                        need <= need - 1'b1;
                        // Last sample of the tile: publish the window including it.
                        if (need == NW'(1)) begin
                            D     <= win_nxt;
                            cnt   <= CW'(LAT - 1);
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // cnt reaches 0 on the LAT-th edge after D changed, when Z is valid.
                    if (cnt == '0) begin
                        res     <= Z;
                        idx     <= '0;
                        m_data  <= Z[W*M-1 -: W];
                        m_valid <= 1'b1;
                        state   <= ST_DRAIN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (m_valid && m_ready) begin
                        if (idx == IW'(M - 1)) begin
                            m_valid <= 1'b0;
                            need    <= NW'(M);
                            state   <= ST_FILL;
                        end else begin
                            idx    <= idx_inc;
                            m_data <= res_e[idx_inc];
                        end
                    end
                end
                default: begin
                    state <= ST_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wc_stream_adapter.sv
module tb_wc_stream_adapter;

    localparam int W    = 10;
    localparam int TILE = 6;
    localparam int M    = 2;
    localparam int LAT  = 6;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [W-1:0]  s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic [W*TILE-1:0]    D;
    logic [W*M-1:0]       Z;
    logic signed [W-1:0]  m_data;
    logic                 m_valid;
    logic                 m_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wc_stream_adapter #(.W(W), .TILE(TILE), .M(M), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .D(D), .Z(Z),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
    );

    // Stub wc core: Z follows D through LAT-1 register stages, so the result of
    // a new tile is present exactly for the LAT-th edge after D changed.
    logic              ovr_en;
    logic [W*TILE-1:0] ovr_d;
    logic [W*M-1:0]    ovr_z;
    logic [W*TILE-1:0] dd [LAT-1];

    always @(posedge clk) begin
        dd[0] <= D;
        for (int i = 1; i < LAT - 1; i++) dd[i] <= dd[i-1];
    end

    function automatic logic [W*M-1:0] wc_stub(input logic [W*TILE-1:0] d, input logic en,
                                               input logic [W*TILE-1:0] od, input logic [W*M-1:0] oz);
        logic [W-1:0] e [TILE];
        if (en && d == od) return oz;
        for (int i = 0; i < TILE; i++) e[i] = d[W*(TILE-i)-1 -: W];
        return {W'(e[0] + e[3] - e[5]), W'(e[1] - e[2] + e[4])};
    endfunction

    assign Z = wc_stub(dd[LAT-2], ovr_en, ovr_d, ovr_z);

    function automatic logic [W-1:0] zel(input logic [W*M-1:0] z, input int i);
        return z[W*(M-i)-1 -: W];
    endfunction

    // Tile k of a stream is samples k*M .. k*M+TILE-1 since reset.
    function automatic logic [W*TILE-1:0] pack(input logic [W-1:0] q[$], input int base);
        logic [W*TILE-1:0] r;
        r = '0;
        for (int i = 0; i < TILE; i++) r[W*(TILE-i)-1 -: W] = q[base+i];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] v, input int idle);
        int  g;
        logic ok;
        s_valid = 1'b0;
        repeat (idle) step();
        s_data  = v;
        s_valid = 1'b1;
        ok = 1'b0;
        g  = 0;
        while (!ok && g <= 200) begin
            ok = s_ready;
            step();
            g++;
        end
        if (!ok) chk("push_timeout", 64'd0, 64'd1);
        s_valid = 1'b0;
    endtask

    task automatic wait_lat(input string nm);
        int lat;
        lat = 0;
        while (!m_valid && lat < 100) begin
            step();
            lat++;
        end
        chk(nm, 64'(lat), 64'(LAT));
    endtask

    task automatic drain(input logic [W*M-1:0] z, input int stall, input bit randrdy);
        int g;
        m_ready = 1'b0;
        for (int k = 0; k < stall; k++) begin
            chk("stall_mvalid", 64'(m_valid), 64'd1);
            chk("stall_mdata", 64'($unsigned(m_data)), 64'(zel(z, 0)));
            chk("stall_sready", 64'(s_ready), 64'd0);
            step();
        end
        for (int i = 0; i < M; i++) begin
            m_ready = randrdy ? 1'($urandom_range(0, 1)) : 1'b1;
            g = 0;
            while (!m_ready && g < 20) begin
                chk("hold_mdata", 64'($unsigned(m_data)), 64'(zel(z, i)));
                step();
                g++;
                m_ready = 1'($urandom_range(0, 1));
            end
            m_ready = 1'b1;
            chk("out_mvalid", 64'(m_valid), 64'd1);
            chk("out_mdata", 64'($unsigned(m_data)), 64'(zel(z, i)));
            step();
        end
        m_ready = 1'b0;
        chk("end_mvalid", 64'(m_valid), 64'd0);
        chk("end_sready", 64'(s_ready), 64'd1);
    endtask

    typedef struct {
        int                n;
        logic [W-1:0]      s [TILE];
        logic [W*M-1:0]    z;
        logic [W*TILE-1:0] d;
        int                stall;
        bit                gap;
    } vec_t;

    vec_t tbl [3];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        logic [W*TILE-1:0] prevd;
        logic [W*TILE-1:0] expd;
        logic [W-1:0]      q[$];
        int                seen;

        tbl[0].n = 6; tbl[0].stall = 0; tbl[0].gap = 1'b0;
        tbl[0].s = '{W'(2), W'(-10), W'(3), W'(4), W'(-13), W'(-18)};
        tbl[0].z = 20'b0000111111_1100101101;
        tbl[0].d = 60'b0000000010_1111110110_0000000011_0000000100_1111110011_1111101110;
        tbl[1].n = 2; tbl[1].stall = 4; tbl[1].gap = 1'b0;
        tbl[1].s = '{W'(-19), W'(-6), W'(0), W'(0), W'(0), W'(0)};
        tbl[1].z = {W'(-136), W'(-213)};
        tbl[1].d = {W'(3), W'(4), W'(-13), W'(-18), W'(-19), W'(-6)};
        tbl[2].n = 2; tbl[2].stall = 1; tbl[2].gap = 1'b1;
        tbl[2].s = '{W'(100), W'(-512), W'(0), W'(0), W'(0), W'(0)};
        tbl[2].z = {W'(511), W'(-512)};
        tbl[2].d = {W'(-13), W'(-18), W'(-19), W'(-6), W'(100), W'(-512)};

        rst = 1'b0; s_valid = 1'b1; s_data = W'(341); m_ready = 1'b0;
        ovr_en = 1'b0; ovr_d = '0; ovr_z = '0;

        // Reset with s_valid asserted.
        for (int k = 0; k < 2; k++) begin
            step();
            chk("rst_sready", 64'(s_ready), 64'd0);
            chk("rst_D", 64'(D), 64'd0);
            chk("rst_mvalid", 64'(m_valid), 64'd0);
            chk("rst_mdata", 64'($unsigned(m_data)), 64'd0);
        end
        s_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("post_rst_sready", 64'(s_ready), 64'd1);

        // Directed tiles: first tile, stride with backpressure, gapped input.
        for (int t = 0; t < 3; t++) begin
            ovr_en = 1'b1; ovr_d = tbl[t].d; ovr_z = tbl[t].z;
            prevd  = (t == 0) ? '0 : tbl[t-1].d;
            for (int k = 0; k < tbl[t].n; k++) begin
                push(tbl[t].s[k], tbl[t].gap ? 1 : 0);
                if (k < tbl[t].n - 1) chk("fill_D_held", 64'(D), 64'(prevd));
            end
            chk("tile_D", 64'(D), 64'(tbl[t].d));
            chk("tile_sready", 64'(s_ready), 64'd0);
            s_valid = 1'b1;
            s_data  = W'(77);
            wait_lat("mvalid_latency");
            drain(tbl[t].z, tbl[t].stall, 1'b0);
            s_valid = 1'b0;
        end
        ovr_en = 1'b0;

        // Reset mid-WAIT.
        push(W'(5), 0);
        push(W'(6), 0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("rstw_mvalid", 64'(m_valid), 64'd0);
        chk("rstw_D", 64'(D), 64'd0);
        rst = 1'b1;
        #1;
        chk("rstw_sready", 64'(s_ready), 64'd1);
        seen = 0;
        for (int k = 0; k < LAT + 4; k++) begin
            step();
            if (m_valid) seen++;
        end
        chk("rstw_no_stale_out", 64'(seen), 64'd0);

        // Fresh tile, then reset mid-DRAIN.
        q.delete();
        for (int k = 0; k < TILE; k++) begin
            q.push_back(W'(k * 37 - 90));
            push(q[k], 0);
        end
        expd = pack(q, 0);
        chk("fresh_D", 64'(D), 64'(expd));
        wait_lat("fresh_latency");
        chk("fresh_out0", 64'($unsigned(m_data)), 64'(zel(wc_stub(expd, 1'b0, '0, '0), 0)));
        step();
        rst = 1'b0;
        step();
        chk("rstd_mvalid", 64'(m_valid), 64'd0);
        chk("rstd_D", 64'(D), 64'd0);
        chk("rstd_mdata", 64'($unsigned(m_data)), 64'd0);
        rst = 1'b1;
        #1;
        q.delete();
        for (int k = 0; k < TILE; k++) begin
            q.push_back(W'(200 - k * 61));
            push(q[k], 0);
            if (k < TILE - 1) chk("rstd_need_tile", 64'(D), 64'd0);
        end
        expd = pack(q, 0);
        chk("rstd_D_after", 64'(D), 64'(expd));
        wait_lat("rstd_latency");
        drain(wc_stub(expd, 1'b0, '0, '0), 0, 1'b0);

        // Randomized stream checked against the sample-list model.
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        q.delete();
        for (int k = 0; k < 20; k++) begin
            int need;
            need = (k == 0) ? TILE : M;
            for (int j = 0; j < need; j++) begin
                logic [W-1:0] v;
                v = W'($urandom);
                q.push_back(v);
                push(v, $urandom_range(0, 2));
            end
            expd = pack(q, k * M);
            chk("rand_D", 64'(D), 64'(expd));
            s_valid = 1'($urandom_range(0, 1));
            s_data  = W'($urandom);
            wait_lat("rand_latency");
            drain(wc_stub(expd, 1'b0, '0, '0), $urandom_range(0, 2), 1'b1);
            s_valid = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
